lsu_mmio_pipe: RTL and testbench

//  Parametrised load/store unit for the RISC-V core: byte-enabled data memory

---
 rtl/lsu_mmio_pipe_pkg.sv | 31 +++
 rtl/lsu_mmio_pipe_dmem.sv | 21 ++
 rtl/lsu_mmio_pipe.sv | 135 +++++++++++++
 tb/tb_lsu_mmio_pipe.sv | 153 +++++++++++++++
 4 files changed

// File: rtl/lsu_mmio_pipe_pkg.sv
// lsu_pkg: shared types, address map and byte-lane helpers for the load/store unit
package lsu_pkg;
  typedef enum logic [2:0] {
    F3_B  = 3'b000,
    F3_H  = 3'b001,
    F3_W  = 3'b010,
    F3_BU = 3'b100,
    F3_HU = 3'b101
  } funct3_e;
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_e;
  localparam logic [31:0] A_LEDR  = 32'h7000;
  localparam logic [31:0] A_LEDG  = 32'h7010;
  localparam logic [31:0] A_HEXLO = 32'h7020;
  localparam logic [31:0] A_HEXHI = 32'h7024;
  localparam logic [31:0] A_LCD   = 32'h7030;
  localparam logic [31:0] A_SW    = 32'h7800;
  localparam logic [31:0] A_BTN   = 32'h7810;
  function automatic logic [3:0] be_gen(input logic [2:0] f3, input logic [1:0] a);
    return f3[1:0] == F3_B[1:0] ? 4'b0001 << a : f3[1:0] == F3_H[1:0] ? 4'b0011 << a : 4'hF;
  endfunction
  function automatic logic [31:0] ld_ext(input logic [31:0] w, input logic [2:0] f3, input logic [1:0] a);
    logic [31:0] s;
    s = w >> {a, 3'b000};
    return f3[1:0] == F3_B[1:0] ? {{24{~f3[2] & s[7]}}, s[7:0]} :
           f3[1:0] == F3_H[1:0] ? {{16{~f3[2] & s[15]}}, s[15:0]} : s;
  endfunction
  function automatic logic [31:0] bmerge(input logic [31:0] o, input logic [31:0] n, input logic [3:0] be);
    for (int i = 0; i < 4; i++) o[8*i+:8] = be[i] ? n[8*i+:8] : o[8*i+:8];
    return o;
  endfunction
endpackage

// File: rtl/lsu_mmio_pipe_dmem.sv
// lsu_dmem: byte-enabled word RAM with an RD_LAT-deep read pipeline
module lsu_dmem #(
  parameter int WORDS  = 2048,
  parameter int RD_LAT = 1
) (
  input  logic                     i_clk,
  input  logic                     i_we,
  input  logic [3:0]               i_be,
  input  logic [$clog2(WORDS)-1:0] i_addr,
  input  logic [31:0]              i_wdata,
  output logic [31:0]              o_rdata
);
  logic [3:0][7:0] mem_q [WORDS];
  logic [31:0] pipe_q [RD_LAT];
  always_ff @(posedge i_clk) begin
    for (int i = 0; i < 4; i++) if (i_we && i_be[i]) mem_q[i_addr][i] <= i_wdata[8*i+:8];
    pipe_q[0] <= mem_q[i_addr];
    for (int i = 1; i < RD_LAT; i++) pipe_q[i] <= pipe_q[i-1];
  end
  always_comb o_rdata = pipe_q[RD_LAT-1];
endmodule

// File: rtl/lsu_mmio_pipe.sv
// lsu_mmio_pipe: load/store unit with byte-enabled DMEM, MMIO peripherals and stall handshake
module lsu_mmio_pipe
  import lsu_pkg::*;
#(
  parameter int ADDR_W     = 16,
  parameter int DMEM_WORDS = 2048,
  parameter int RD_LAT     = 1,
  parameter int NUM_HEX    = 8
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_req,
  input  logic                 i_wren,
  input  logic [2:0]           i_funct3,
  input  logic [31:0]          i_addr,
  input  logic [31:0]          i_st_data,
  output logic                 o_stall,
  output logic                 o_ld_valid,
  output logic [31:0]          o_ld_data,
  output logic                 o_misalign,
  input  logic [31:0]          i_io_sw,
  input  logic [31:0]          i_io_btn,
  output logic [31:0]          o_io_ledr,
  output logic [31:0]          o_io_ledg,
  output logic [7*NUM_HEX-1:0] o_io_hex,
  output logic [31:0]          o_io_lcd
);
  localparam int AW = $clog2(DMEM_WORDS);
  localparam logic [1:0] CNT0 = 2'(RD_LAT - 1);
  state_e state_d, state_q;
  logic [1:0] cnt_d, cnt_q, alo_d, alo_q;
  logic [2:0] f3_d, f3_q;
  logic [ADDR_W-1:0] a;
  logic [31:0] wa, wdata, mmio_word, dmem_word, dmem_ext;
  logic [31:0] ledr_d, ledr_q, ledg_d, ledg_q, hexlo_d, hexlo_q, hexhi_d, hexhi_q, lcd_d, lcd_q;
  logic [31:0] sw_meta_d, sw_meta_q, sw_sync_d, sw_sync_q, btn_meta_d, btn_meta_q, btn_sync_d, btn_sync_q;
  logic [31:0] ld_data_d, ld_data_q;
  logic mvalid_d, mvalid_q, mis_d, mis_q;
  logic [3:0] be;
  logic bad, go, ld, st, in_dmem;
  logic [63:0] hex_all;
  logic unused_ok;
  always_comb begin
    a = i_addr[ADDR_W-1:0];
    wa = 32'({a[ADDR_W-1:2], 2'b00});
    in_dmem = 32'(a) < 32'(4 * DMEM_WORDS);
    bad = (&i_funct3[1:0]) | (i_funct3[2] & i_funct3[1]) |
          (i_funct3[1:0] == F3_H[1:0] & a[0]) | (i_funct3[1:0] == F3_W[1:0] & |a[1:0]);
    go = i_req & state_q != WAIT;
    st = go & ~bad & i_wren;
    ld = go & ~bad & ~i_wren;
    be = be_gen(i_funct3, a[1:0]);
    wdata = i_funct3[1:0] == F3_B[1:0] ? {4{i_st_data[7:0]}} :
            i_funct3[1:0] == F3_H[1:0] ? {2{i_st_data[15:0]}} : i_st_data;
    ledr_d  = st & wa == A_LEDR  ? bmerge(ledr_q, wdata, be)  : ledr_q;
    ledg_d  = st & wa == A_LEDG  ? bmerge(ledg_q, wdata, be)  : ledg_q;
    hexlo_d = st & wa == A_HEXLO ? bmerge(hexlo_q, wdata, be) : hexlo_q;
    hexhi_d = st & wa == A_HEXHI ? bmerge(hexhi_q, wdata, be) : hexhi_q;
    lcd_d   = st & wa == A_LCD   ? bmerge(lcd_q, wdata, be)   : lcd_q;
    sw_meta_d = i_io_sw;
    sw_sync_d = sw_meta_q;
    btn_meta_d = i_io_btn;
    btn_sync_d = btn_meta_q;
    mmio_word = wa == A_LEDR  ? ledr_q  : wa == A_LEDG  ? ledg_q  :
                wa == A_HEXLO ? hexlo_q : wa == A_HEXHI ? hexhi_q :
                wa == A_LCD   ? lcd_q   : wa == A_SW    ? sw_sync_q :
                wa == A_BTN   ? btn_sync_q : 32'h0;
    dmem_ext = ld_ext(dmem_word, f3_q, alo_q);
    mvalid_d = ld & ~in_dmem;
    mis_d = go & bad;
    f3_d = ld & in_dmem ? i_funct3 : f3_q;
    alo_d = ld & in_dmem ? a[1:0] : alo_q;
    // WAIT holds for RD_LAT-1 cycles so RESP lines up with the RAM pipeline output
    state_d = state_q == WAIT ? (cnt_q == 2'd1 ? RESP : WAIT) :
              ld & in_dmem ? (RD_LAT == 1 ? RESP : WAIT) : IDLE;
    cnt_d = state_q == WAIT ? cnt_q - 2'd1 : CNT0;
    ld_data_d = mvalid_d ? ld_ext(mmio_word, i_funct3, a[1:0]) : state_q == RESP ? dmem_ext : ld_data_q;
    o_stall = state_q == WAIT;
    o_ld_valid = state_q == RESP | mvalid_q;
    o_ld_data = state_q == RESP ? dmem_ext : ld_data_q;
    o_misalign = mis_q;
    o_io_ledr = ledr_q;
    o_io_ledg = ledg_q;
    o_io_lcd = lcd_q;
    hex_all = {hexhi_q, hexlo_q};
    o_io_hex = '0;
    for (int i = 0; i < NUM_HEX; i++) o_io_hex[7*i+:7] = hex_all[8*i+:7];
    unused_ok = ^{i_addr[31:ADDR_W], hex_all};
  end
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= IDLE;
      cnt_q <= '0;
      f3_q <= '0;
      alo_q <= '0;
      ledr_q <= '0;
      ledg_q <= '0;
      hexlo_q <= '0;
      hexhi_q <= '0;
      lcd_q <= '0;
      sw_meta_q <= '0;
      sw_sync_q <= '0;
      btn_meta_q <= '0;
      btn_sync_q <= '0;
      ld_data_q <= '0;
      mvalid_q <= 1'b0;
      mis_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      f3_q <= f3_d;
      alo_q <= alo_d;
      ledr_q <= ledr_d;
      ledg_q <= ledg_d;
      hexlo_q <= hexlo_d;
      hexhi_q <= hexhi_d;
      lcd_q <= lcd_d;
      sw_meta_q <= sw_meta_d;
      sw_sync_q <= sw_sync_d;
      btn_meta_q <= btn_meta_d;
      btn_sync_q <= btn_sync_d;
      ld_data_q <= ld_data_d;
      mvalid_q <= mvalid_d;
      mis_q <= mis_d;
    end
  end
  lsu_dmem #(.WORDS(DMEM_WORDS), .RD_LAT(RD_LAT)) u_dmem (
    .i_clk  (i_clk),
    .i_we   (st & in_dmem),
    .i_be   (be),
    .i_addr (a[AW+1:2]),
    .i_wdata(wdata),
    .o_rdata(dmem_word)
  );
endmodule

// File: tb/tb_lsu_mmio_pipe.sv
// tb_lsu_mmio_pipe: directed checks of loads, stores, MMIO, misalign and reset with RD_LAT=2
module tb_lsu_mmio_pipe;
  localparam logic [2:0] B = 3'b000, H = 3'b001, W = 3'b010, BU = 3'b100, HU = 3'b101;
  localparam logic [55:0] HEX03 = 56'h04 | (56'h03 << 7) | (56'h02 << 14) | (56'h01 << 21);
  logic clk = 0, rst = 1, req = 0, wren = 0;
  logic [2:0] f3 = 0;
  logic [31:0] addr = 0, st_data = 0, sw = 0, btn = 0;
  logic stall, ld_valid, misalign;
  logic [31:0] ld_data, ledr, ledg, lcd;
  logic [55:0] hex;
  int n_chk = 0, n_err = 0;
  always #5 clk = ~clk;
  lsu_mmio_pipe #(.ADDR_W(16), .DMEM_WORDS(2048), .RD_LAT(2), .NUM_HEX(8)) dut (
    .i_clk(clk), .i_rst(rst), .i_req(req), .i_wren(wren), .i_funct3(f3), .i_addr(addr),
    .i_st_data(st_data), .o_stall(stall), .o_ld_valid(ld_valid), .o_ld_data(ld_data),
    .o_misalign(misalign), .i_io_sw(sw), .i_io_btn(btn), .o_io_ledr(ledr), .o_io_ledg(ledg),
    .o_io_hex(hex), .o_io_lcd(lcd)
  );
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic issue(input logic w, input logic [2:0] f, input logic [31:0] ad, input logic [31:0] d);
    @(negedge clk);
    wren = w; f3 = f; addr = ad; st_data = d; req = 1;
  endtask
  task automatic do_st(input logic [2:0] f, input logic [31:0] ad, input logic [31:0] d);
    issue(1, f, ad, d);
    @(negedge clk);
    chk("st_stall", stall, 0);
    req = 0;
  endtask
  task automatic ld_io(input string tag, input logic [2:0] f, input logic [31:0] ad, input logic [31:0] exp);
    issue(0, f, ad, 0);
    @(negedge clk);
    chk({tag, "_valid"}, ld_valid, 1);
    chk(tag, ld_data, exp);
    req = 0;
  endtask
  task automatic ld_mem(input string tag, input logic [2:0] f, input logic [31:0] ad, input logic [31:0] exp);
    int stalls = 0;
    bit got = 0;
    issue(0, f, ad, 0);
    for (int i = 0; i < 8 && !got; i++) begin
      @(negedge clk);
      if (ld_valid) got = 1;
      else if (stall) stalls++;
    end
    req = 0;
    chk({tag, "_valid"}, got, 1);
    chk({tag, "_stall"}, stalls, 1);
    chk(tag, ld_data, exp);
  endtask
  task automatic bad_acc(input string tag, input logic w, input logic [2:0] f, input logic [31:0] ad);
    issue(w, f, ad, 32'hFFFF_FFFF);
    @(negedge clk);
    chk({tag, "_mis"}, misalign, 1);
    chk({tag, "_novalid"}, ld_valid, 0);
    req = 0;
    @(negedge clk);
    chk({tag, "_mis_end"}, misalign, 0);
  endtask
  initial begin
    repeat (2) @(negedge clk);
    chk("rst_stall", stall, 0);
    chk("rst_valid", ld_valid, 0);
    chk("rst_mis", misalign, 0);
    chk("rst_data", ld_data, 0);
    chk("rst_ledr", ledr, 0);
    chk("rst_ledg", ledg, 0);
    chk("rst_hex", hex, 0);
    chk("rst_lcd", lcd, 0);
    rst = 0; sw = 32'hCAFE_F00D; wren = 0; f3 = W; addr = 32'h7800; req = 1;
    @(negedge clk);
    chk("sw_early_valid", ld_valid, 1);
    chk("sw_early", ld_data, 0);
    req = 0;
    repeat (2) @(negedge clk);
    ld_io("sw_sync", W, 32'h7800, 32'hCAFE_F00D);
    @(negedge clk);
    btn = 32'h5A5A_0001; wren = 0; f3 = W; addr = 32'h7810; req = 1;
    @(negedge clk);
    chk("btn_edge1", ld_data, 0);
    @(negedge clk);
    chk("btn_edge2", ld_data, 0);
    @(negedge clk);
    chk("btn_edge3", ld_data, 32'h5A5A_0001);
    req = 0;
    do_st(W, 32'h0, 32'h0);
    do_st(B, 32'h3, 32'hAB);
    ld_mem("lw0", W, 32'h0, 32'hAB00_0000);
    ld_mem("lb3", B, 32'h3, 32'hFFFF_FFAB);
    ld_mem("lbu3", BU, 32'h3, 32'h0000_00AB);
    ld_mem("lh2", H, 32'h2, 32'hFFFF_AB00);
    ld_mem("lhu2", HU, 32'h2, 32'h0000_AB00);
    do_st(W, 32'h10, 32'h8001_7F02);
    ld_mem("lb11", B, 32'h11, 32'h0000_007F);
    ld_mem("lb13", B, 32'h13, 32'hFFFF_FF80);
    ld_mem("lh12", H, 32'h12, 32'hFFFF_8001);
    do_st(W, 32'h1FFC, 32'h1357_9BDF);
    ld_mem("lw_top", W, 32'h1FFC, 32'h1357_9BDF);
    @(negedge clk);
    chk("hold_valid", ld_valid, 0);
    chk("hold_data", ld_data, 32'h1357_9BDF);
    bad_acc("lw2", 0, W, 32'h2);
    bad_acc("f3_011", 0, 3'b011, 32'h0);
    bad_acc("sh1", 1, H, 32'h1);
    ld_mem("after_sh1", W, 32'h0, 32'hAB00_0000);
    do_st(W, 32'h7000, 32'h1122_3344);
    chk("ledr_w", ledr, 32'h1122_3344);
    do_st(B, 32'h7002, 32'hEE);
    chk("ledr_b", ledr, 32'h11EE_3344);
    ld_io("ledr_rb", W, 32'h7000, 32'h11EE_3344);
    ld_io("ledr_hiaddr", W, 32'h0001_7000, 32'h11EE_3344);
    do_st(H, 32'h7012, 32'hBEEF);
    chk("ledg_h", ledg, 32'hBEEF_0000);
    do_st(W, 32'h7030, 32'hDEAD_BEEF);
    chk("lcd_w", lcd, 32'hDEAD_BEEF);
    do_st(W, 32'h7020, 32'h0102_0304);
    chk("hex03", hex, HEX03);
    do_st(B, 32'h7025, 32'h3F);
    chk("hex5", hex, HEX03 | (56'h3F << 35));
    ld_io("hex5_rb", BU, 32'h7025, 32'h3F);
    ld_io("unmapped", W, 32'h7040, 32'h0);
    ld_io("dmem_end", W, 32'h2000, 32'h0);
    do_st(W, 32'h7040, 32'hFFFF_FFFF);
    chk("unmapped_st", ledr, 32'h11EE_3344);
    issue(0, W, 32'h0, 0);
    @(negedge clk);
    chk("mid_stall", stall, 1);
    req = 0;
    #2 rst = 1;
    #1;
    chk("mid_rst_stall", stall, 0);
    chk("mid_rst_valid", ld_valid, 0);
    chk("mid_rst_data", ld_data, 0);
    chk("mid_rst_ledr", ledr, 0);
    chk("mid_rst_hex", hex, 0);
    chk("mid_rst_lcd", lcd, 0);
    @(negedge clk);
    rst = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("post_rst_novalid", ld_valid, 0);
    end
    ld_mem("post_rst_lw", W, 32'h0, 32'hAB00_0000);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
